// File: rtl/writeback_regfile_ctrl_if.sv
// Write-port handshake bundle between the two writeback requesters (execute, memaccess)
// and the writeback controller.
interface writeback_regfile_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              req_exe;
    logic [ADDR_W-1:0] exe_dr;
    logic [DATA_W-1:0] exe_data;
    logic              ack_exe;

    logic              req_mem;
    logic [ADDR_W-1:0] mem_dr;
    logic [DATA_W-1:0] mem_data;
    logic              ack_mem;

    modport master (
        output req_exe, exe_dr, exe_data,
        input  ack_exe,
        output req_mem, mem_dr, mem_data,
        input  ack_mem
    );

    modport slave (
        input  req_exe, exe_dr, exe_data,
        output ack_exe,
        input  req_mem, mem_dr, mem_data,
        output ack_mem
    );
endinterface

// File: rtl/writeback_regfile_ctrl.sv
// LC3 writeback controller: arbitrates the single register-file write port between execute and
// memaccess, owns the 8x16 register file and NZP psr. Define WB_BYPASS_EN for write-to-read bypass.
module writeback_regfile_ctrl #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int ARB_MODE = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    writeback_regfile_ctrl_if.slave   wb,
    input  logic                      enable_writeback,
    input  logic [ADDR_W-1:0]         sr1,
    input  logic [ADDR_W-1:0]         sr2,
    output logic [DATA_W-1:0]         vsr1,
    output logic [DATA_W-1:0]         vsr2,
    output logic [2:0]                psr,
    output logic                      enable_writeback_out,
    output logic [15:0]               wb_count
);

    localparam logic [0:0] GRANT_EXE = 1'b0;
    localparam logic [0:0] GRANT_MEM = 1'b1;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [0:0]        last_grant;
    logic              grant_exe;
    logic              grant_mem;
    logic              commit;
    logic [ADDR_W-1:0] commit_dr;
    logic [DATA_W-1:0] commit_data;
    logic [2:0]        psr_next;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;

    // Under contention, round-robin favours whoever was not served last; mode 1 always favours loads.
    always_comb begin
        grant_exe = 1'b0;
        grant_mem = 1'b0;
        if (enable_writeback) begin
            if (wb.req_exe && wb.req_mem) begin
                if (ARB_MODE == 1 || last_grant == GRANT_EXE) begin
                    grant_mem = 1'b1;
                end else begin
                    grant_exe = 1'b1;
                end
            end else begin
                grant_exe = wb.req_exe;
                grant_mem = wb.req_mem;
            end
        end
    end

    assign wb.ack_exe  = grant_exe;
    assign wb.ack_mem  = grant_mem;
    assign commit      = grant_exe | grant_mem;
    assign commit_dr   = grant_mem ? wb.mem_dr   : wb.exe_dr;
    assign commit_data = grant_mem ? wb.mem_data : wb.exe_data;

    assign psr_next = {commit_data[DATA_W-1],
                       commit_data == '0,
                       ~commit_data[DATA_W-1] & (commit_data != '0)};

`ifdef WB_BYPASS_EN
    assign rd1_data = (commit && commit_dr == sr1) ? commit_data : regs[sr1];
    assign rd2_data = (commit && commit_dr == sr2) ? commit_data : regs[sr2];
`else
    assign rd1_data = regs[sr1];
    assign rd2_data = regs[sr2];
`endif

    // Reset starts last_grant at MEM so execute wins the first contention.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            vsr1                 <= '0;
            vsr2                 <= '0;
            psr                  <= 3'b010;
            enable_writeback_out <= 1'b0;
            wb_count             <= 16'd0;
            last_grant           <= GRANT_MEM;
        end else begin
            if (commit) begin
                regs[commit_dr] <= commit_data;
                psr             <= psr_next;
                wb_count        <= wb_count + 16'd1;
                last_grant      <= grant_mem ? GRANT_MEM : GRANT_EXE;
            end
            enable_writeback_out <= commit;
            vsr1                 <= rd1_data;
            vsr2                 <= rd2_data;
        end
    end

endmodule

// File: tb/tb_writeback_regfile_ctrl.sv
// Bench for writeback_regfile_ctrl: instance 0 uses round-robin, instance 1 fixed mem priority.
// Directed vector tables, a random run against a reference model, and a wb_count wrap/reset sequence.
module tb_writeback_regfile_ctrl;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_writeback;
    logic [2:0]  sr1, sr2;

    logic        req_exe  [2];
    logic [2:0]  exe_dr   [2];
    logic [15:0] exe_data [2];
    logic        req_mem  [2];
    logic [2:0]  mem_dr   [2];
    logic [15:0] mem_data [2];

    logic        ack_exe  [2];
    logic        ack_mem  [2];
    logic [15:0] vsr1     [2];
    logic [15:0] vsr2     [2];
    logic [2:0]  psr      [2];
    logic        ewo      [2];
    logic [15:0] wb_count [2];

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    writeback_regfile_ctrl_if bus0 ();
    writeback_regfile_ctrl_if bus1 ();

    assign bus0.req_exe  = req_exe[0];
    assign bus0.exe_dr   = exe_dr[0];
    assign bus0.exe_data = exe_data[0];
    assign bus0.req_mem  = req_mem[0];
    assign bus0.mem_dr   = mem_dr[0];
    assign bus0.mem_data = mem_data[0];
    assign ack_exe[0]    = bus0.ack_exe;
    assign ack_mem[0]    = bus0.ack_mem;

    assign bus1.req_exe  = req_exe[1];
    assign bus1.exe_dr   = exe_dr[1];
    assign bus1.exe_data = exe_data[1];
    assign bus1.req_mem  = req_mem[1];
    assign bus1.mem_dr   = mem_dr[1];
    assign bus1.mem_data = mem_data[1];
    assign ack_exe[1]    = bus1.ack_exe;
    assign ack_mem[1]    = bus1.ack_mem;

    writeback_regfile_ctrl #(.ARB_MODE(0)) dut0 (
        .clock(clock), .reset(reset), .wb(bus0),
        .enable_writeback(enable_writeback), .sr1(sr1), .sr2(sr2),
        .vsr1(vsr1[0]), .vsr2(vsr2[0]), .psr(psr[0]),
        .enable_writeback_out(ewo[0]), .wb_count(wb_count[0])
    );

    writeback_regfile_ctrl #(.ARB_MODE(1)) dut1 (
        .clock(clock), .reset(reset), .wb(bus1),
        .enable_writeback(enable_writeback), .sr1(sr1), .sr2(sr2),
        .vsr1(vsr1[1]), .vsr2(vsr2[1]), .psr(psr[1]),
        .enable_writeback_out(ewo[1]), .wb_count(wb_count[1])
    );

    typedef struct packed {
        logic        en;
        logic        re;
        logic [2:0]  edr;
        logic [15:0] ed;
        logic        rm;
        logic [2:0]  mdr;
        logic [15:0] md;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic        ae;
        logic        am;
        logic [2:0]  p;
        logic        wo;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl0 [12];
    vec_t tbl1 [6];

    // Reference model state, one copy per instance
    logic [15:0] m_regs [2][8];
    logic        m_last_mem [2];
    logic [2:0]  m_psr [2];
    logic        m_ewo [2];
    logic [15:0] m_cnt [2];
    logic [15:0] m_vsr1 [2];
    logic [15:0] m_vsr2 [2];
    logic        g_exe [2];
    logic        g_mem [2];

    task automatic check_output(string name, int i, logic [15:0] act, logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s[%0d]: got %h, expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        for (int i = 0; i < 2; i++) begin
            req_exe[i] = 1'b0; exe_dr[i] = 3'd0; exe_data[i] = 16'h0;
            req_mem[i] = 1'b0; mem_dr[i] = 3'd0; mem_data[i] = 16'h0;
        end
        enable_writeback = 1'b1;
        sr1 = 3'd0;
        sr2 = 3'd0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check_output("rst_vsr1", i, vsr1[i], 16'h0);
            check_output("rst_vsr2", i, vsr2[i], 16'h0);
            check_output("rst_psr", i, {13'd0, psr[i]}, 16'h0002);
            check_output("rst_ewo", i, {15'd0, ewo[i]}, 16'h0);
            check_output("rst_cnt", i, wb_count[i], 16'h0);
            for (int r = 0; r < 8; r++) m_regs[i][r] = 16'h0;
            m_last_mem[i] = 1'b1;
            m_psr[i] = 3'b010;
            m_ewo[i] = 1'b0;
            m_cnt[i] = 16'h0;
            m_vsr1[i] = 16'h0;
            m_vsr2[i] = 16'h0;
            g_exe[i] = 1'b0;
            g_mem[i] = 1'b0;
        end
        reset = 1'b1;
    endtask

    // Drive one table row on instance i (the other stays idle) and check it across one edge
    task automatic apply_stimulus(int i, vec_t v);
        set_idle();
        enable_writeback = v.en;
        sr1 = v.s1;
        sr2 = v.s2;
        req_exe[i] = v.re; exe_dr[i] = v.edr; exe_data[i] = v.ed;
        req_mem[i] = v.rm; mem_dr[i] = v.mdr; mem_data[i] = v.md;
        #1;
        check_output("tbl_ack_exe", i, {15'd0, ack_exe[i]}, {15'd0, v.ae});
        check_output("tbl_ack_mem", i, {15'd0, ack_mem[i]}, {15'd0, v.am});
        @(posedge clock);
        #1;
        check_output("tbl_psr", i, {13'd0, psr[i]}, {13'd0, v.p});
        check_output("tbl_ewo", i, {15'd0, ewo[i]}, {15'd0, v.wo});
        check_output("tbl_vsr1", i, vsr1[i], v.v1);
        check_output("tbl_vsr2", i, vsr2[i], v.v2);
        check_output("tbl_cnt", i, wb_count[i], v.cnt);
    endtask

    // Instance 1 is the fixed-priority build
    function automatic logic [1:0] model_grant(int i);
        if (!enable_writeback) return 2'b00;
        if (req_exe[i] && req_mem[i]) begin
            if (i == 1) return 2'b01;
            return m_last_mem[i] ? 2'b10 : 2'b01;
        end
        return {req_exe[i], req_mem[i]};
    endfunction

    task automatic model_edge(int i, logic [1:0] g);
        logic [15:0] d;
        logic [2:0]  a;
        m_vsr1[i] = m_regs[i][sr1];
        m_vsr2[i] = m_regs[i][sr2];
        if (g != 2'b00) begin
            d = g[0] ? mem_data[i] : exe_data[i];
            a = g[0] ? mem_dr[i] : exe_dr[i];
            m_regs[i][a] = d;
            if (BYP && a == sr1) m_vsr1[i] = d;
            if (BYP && a == sr2) m_vsr2[i] = d;
            m_psr[i] = d[15] ? 3'b100 : ((d == 16'h0) ? 3'b010 : 3'b001);
            m_cnt[i] = m_cnt[i] + 16'd1;
            m_last_mem[i] = g[0];
        end
        m_ewo[i] = (g != 2'b00);
    endtask

    task automatic model_cycle();
        logic [1:0] g [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            g[i] = model_grant(i);
            check_output("rnd_ack_exe", i, {15'd0, ack_exe[i]}, {15'd0, g[i][1]});
            check_output("rnd_ack_mem", i, {15'd0, ack_mem[i]}, {15'd0, g[i][0]});
            g_exe[i] = g[i][1];
            g_mem[i] = g[i][0];
        end
        @(posedge clock);
        for (int i = 0; i < 2; i++) model_edge(i, g[i]);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("rnd_vsr1", i, vsr1[i], m_vsr1[i]);
            check_output("rnd_vsr2", i, vsr2[i], m_vsr2[i]);
            check_output("rnd_psr", i, {13'd0, psr[i]}, {13'd0, m_psr[i]});
            check_output("rnd_ewo", i, {15'd0, ewo[i]}, {15'd0, m_ewo[i]});
            check_output("rnd_cnt", i, wb_count[i], m_cnt[i]);
        end
    endtask

    function automatic logic [15:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 16'h0;
            1:       return 16'h8000 | 16'($urandom);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        set_idle();

        // Round-robin build: contention, single requests, enable low, read-before-write, R0 write
        tbl0[0]  = '{1'b1, 1'b1, 3'd1, 16'h0005, 1'b1, 3'd2, 16'hFFFF, 3'd4, 3'd4, 1'b1, 1'b0, 3'b001, 1'b1, 16'h0000, 16'h0000, 16'd1};
        tbl0[1]  = '{1'b1, 1'b1, 3'd3, 16'h0000, 1'b1, 3'd2, 16'hFFFF, 3'd1, 3'd1, 1'b0, 1'b1, 3'b100, 1'b1, 16'h0005, 16'h0005, 16'd2};
        tbl0[2]  = '{1'b1, 1'b1, 3'd3, 16'h0000, 1'b1, 3'd4, 16'h7FFF, 3'd2, 3'd1, 1'b1, 1'b0, 3'b010, 1'b1, 16'hFFFF, 16'h0005, 16'd3};
        tbl0[3]  = '{1'b1, 1'b1, 3'd5, 16'h1234, 1'b1, 3'd4, 16'h7FFF, 3'd3, 3'd0, 1'b0, 1'b1, 3'b001, 1'b1, 16'h0000, 16'h0000, 16'd4};
        tbl0[4]  = '{1'b1, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd6, 1'b1, 1'b0, 3'b001, 1'b1, 16'h7FFF, 16'h0000, 16'd5};
        tbl0[5]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0000, 3'd5, 3'd5, 1'b0, 1'b0, 3'b001, 1'b0, 16'h1234, 16'h1234, 16'd5};
        tbl0[6]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0000, 3'd2, 3'd4, 1'b0, 1'b1, 3'b010, 1'b1, 16'hFFFF, 16'h7FFF, 16'd6};
        tbl0[7]  = '{1'b0, 1'b1, 3'd7, 16'h0F0F, 1'b1, 3'd7, 16'hF0F0, 3'd6, 3'd0, 1'b0, 1'b0, 3'b010, 1'b0, 16'h0000, 16'h0000, 16'd6};
        tbl0[8]  = '{1'b1, 1'b1, 3'd5, 16'h0042, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd5, 1'b1, 1'b0, 3'b001, 1'b1, 16'h0005,
                     BYP ? 16'h0042 : 16'h1234, 16'd7};
        tbl0[9]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b0, 1'b0, 3'b001, 1'b0, 16'h0042, 16'h0042, 16'd7};
        tbl0[10] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h8000, 3'd0, 3'd0, 1'b0, 1'b1, 3'b100, 1'b1,
                     BYP ? 16'h8000 : 16'h0000, BYP ? 16'h8000 : 16'h0000, 16'd8};
        tbl0[11] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b0, 1'b0, 3'b100, 1'b0, 16'h8000, 16'h0000, 16'd8};

        // Fixed-priority build: mem wins four contended cycles while exe holds, then exe is served
        tbl1[0] = '{1'b1, 1'b1, 3'd1, 16'h0005, 1'b1, 3'd2, 16'h8000, 3'd0, 3'd0, 1'b0, 1'b1, 3'b100, 1'b1, 16'h0000, 16'h0000, 16'd1};
        tbl1[1] = '{1'b1, 1'b1, 3'd1, 16'h0005, 1'b1, 3'd3, 16'h0000, 3'd2, 3'd2, 1'b0, 1'b1, 3'b010, 1'b1, 16'h8000, 16'h8000, 16'd2};
        tbl1[2] = '{1'b1, 1'b1, 3'd1, 16'h0005, 1'b1, 3'd4, 16'h0001, 3'd3, 3'd1, 1'b0, 1'b1, 3'b001, 1'b1, 16'h0000, 16'h0000, 16'd3};
        tbl1[3] = '{1'b1, 1'b1, 3'd1, 16'h0005, 1'b1, 3'd2, 16'hFFFE, 3'd4, 3'd4, 1'b0, 1'b1, 3'b100, 1'b1, 16'h0001, 16'h0001, 16'd4};
        tbl1[4] = '{1'b1, 1'b1, 3'd1, 16'h0005, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b1, 1'b0, 3'b001, 1'b1, 16'hFFFE, 16'h0000, 16'd5};
        tbl1[5] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 1'b0, 1'b0, 3'b001, 1'b0, 16'h0005, 16'hFFFE, 16'd5};

        do_reset();
        for (int k = 0; k < 12; k++) apply_stimulus(0, tbl0[k]);

        do_reset();
        for (int k = 0; k < 6; k++) apply_stimulus(1, tbl1[k]);

        // Random traffic obeying hold-until-ack, both instances in lockstep with the model
        do_reset();
        for (int c = 0; c < 500; c++) begin
            enable_writeback = ($urandom_range(0, 7) != 0);
            sr1 = 3'($urandom);
            sr2 = ($urandom_range(0, 3) == 0) ? sr1 : 3'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (!req_exe[i] || g_exe[i]) begin
                    req_exe[i]  = ($urandom_range(0, 2) != 0);
                    exe_dr[i]   = 3'($urandom);
                    exe_data[i] = rand_data();
                end
                if (!req_mem[i] || g_mem[i]) begin
                    req_mem[i]  = ($urandom_range(0, 2) != 0);
                    mem_dr[i]   = 3'($urandom);
                    mem_data[i] = rand_data();
                end
            end
            model_cycle();
        end

        // 65535 back-to-back writes, one wrapping write, then reset in the middle of a request
        do_reset();
        sr1 = 3'd7;
        sr2 = 3'd7;
        req_exe[0] = 1'b1; exe_dr[0] = 3'd7; exe_data[0] = 16'h1234;
        req_mem[1] = 1'b1; mem_dr[1] = 3'd7; mem_data[1] = 16'h1234;
        repeat (65535) @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("full_cnt", i, wb_count[i], 16'hFFFF);
            check_output("full_vsr1", i, vsr1[i], 16'h1234);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("wrap_cnt", i, wb_count[i], 16'h0000);
            check_output("wrap_ewo", i, {15'd0, ewo[i]}, 16'h0001);
        end
        #3;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("midrst_vsr1", i, vsr1[i], 16'h0);
            check_output("midrst_vsr2", i, vsr2[i], 16'h0);
            check_output("midrst_psr", i, {13'd0, psr[i]}, 16'h0002);
            check_output("midrst_ewo", i, {15'd0, ewo[i]}, 16'h0);
            check_output("midrst_cnt", i, wb_count[i], 16'h0);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) check_output("inrst_cnt", i, wb_count[i], 16'h0);
        @(negedge clock);
        req_exe[0] = 1'b0;
        req_mem[1] = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output("postrst_r7", i, vsr1[i], 16'h0);
            check_output("postrst_cnt", i, wb_count[i], 16'h0);
            check_output("postrst_ewo", i, {15'd0, ewo[i]}, 16'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
